csr_counter: RTL and testbench



---
 rtl/csr_counter.sv | 128 ++++++++++++
 tb/tb_csr_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_counter.sv
// Purpose : machine-level cycle / instret counter CSRs (64-bit each) for the RV32 pipeline.
// Latency : one cycle from the request edge to rdata/valid.
// Backpres: none; a request may be issued every cycle.
//
// Ports:
//   clk      system clock, rising edge
//   rstn     asynchronous active-low reset
//   retired  one instruction retired this cycle
//   read     CSR access request (read plus optional modify)
//   modify   00 none, 01 write, 10 set bits, 11 clear bits
//   wdata    operand for the modify operation
//   addr     CSR address
//   rdata    registered old value of the addressed word (0 if unrecognised)
//   valid    registered "address recognised" flag
module csr_counter (
   input  logic        clk,
   input  logic        rstn,
   input  logic        retired,
   input  logic        read,
   input  logic [1:0]  modify,
   input  logic [31:0] wdata,
   input  logic [11:0] addr,
   output logic [31:0] rdata,
   output logic        valid
);

   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_TIME      = 12'hC01;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_TIMEH     = 12'hC81;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;

   logic [63:0] cycle_q,   cycle_d;
   logic [63:0] instret_q, instret_d;
   logic [31:0] rdata_q,   rdata_d;
   logic        valid_q,   valid_d;

   logic        hit;
   logic        writable;
   logic [31:0] sel_word;
   logic [31:0] new_word;
   logic        wr_en;
   logic [63:0] cycle_inc;
   logic [63:0] instret_inc;

   // Address decode and read mux
   always_comb begin
      hit      = 1'b1;
      writable = 1'b0;
      sel_word = 32'd0;
      case (addr)
         A_MCYCLE:    begin sel_word = cycle_q[31:0];    writable = 1'b1; end
         A_MCYCLEH:   begin sel_word = cycle_q[63:32];   writable = 1'b1; end
         A_MINSTRET:  begin sel_word = instret_q[31:0];  writable = 1'b1; end
         A_MINSTRETH: begin sel_word = instret_q[63:32]; writable = 1'b1; end
         A_CYCLE,
         A_TIME:      sel_word = cycle_q[31:0];
         A_CYCLEH,
         A_TIMEH:     sel_word = cycle_q[63:32];
         A_INSTRET:   sel_word = instret_q[31:0];
         A_INSTRETH:  sel_word = instret_q[63:32];
         default:     hit = 1'b0;
      endcase
   end

   // Read-modify-write operand; only the 0xBxx words accept it
   always_comb begin
      new_word = wdata;
      case (modify)
         2'b10:   new_word = sel_word | wdata;
         2'b11:   new_word = sel_word & ~wdata;
         default: new_word = wdata;
      endcase
   end

   assign wr_en = read && writable && (modify != 2'b00);

   always_comb begin
      cycle_inc   = cycle_q + 64'd1;
      instret_inc = instret_q + {63'd0, retired};
      cycle_d     = cycle_inc;
      instret_d   = instret_inc;
      if (wr_en) begin
         case (addr)
            // Low-word write: no +1 on the low word and no carry into the high word
            A_MCYCLE:    cycle_d   = {cycle_q[63:32], new_word};
            // High-word write: low word keeps counting, its carry-out is discarded
            A_MCYCLEH:   cycle_d   = {new_word, cycle_inc[31:0]};
            // A retire coinciding with a minstret write is dropped
            A_MINSTRET:  instret_d = {instret_q[63:32], new_word};
            A_MINSTRETH: instret_d = {new_word, instret_inc[31:0]};
            default: ;
         endcase
      end
   end

   // rdata holds its value when no request is presented
   always_comb begin
      valid_d = read && hit;
      rdata_d = rdata_q;
      if (read) begin
         rdata_d = hit ? sel_word : 32'd0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycle_q   <= 64'd0;
         instret_q <= 64'd0;
         rdata_q   <= 32'd0;
         valid_q   <= 1'b0;
      end else begin
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
         rdata_q   <= rdata_d;
         valid_q   <= valid_d;
      end
   end

   assign rdata = rdata_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_csr_counter.sv
// Purpose : self-checking bench for csr_counter with a queue-based scoreboard.
// Latency : expects results one cycle after each request edge.
// Backpres: none; stimulus may issue a request every cycle.
module tb_csr_counter;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        retired = 1'b0;
   logic        read = 1'b0;
   logic [1:0]  modify = 2'b00;
   logic [31:0] wdata = 32'd0;
   logic [11:0] addr = 12'd0;
   logic [31:0] rdata;
   logic        valid;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic        v;
      logic [31:0] d;
   } exp_t;

   exp_t exp_q[$];

   // Reference state
   logic [63:0] m_cyc = 64'd0;
   logic [63:0] m_ins = 64'd0;
   logic [31:0] m_rdata = 32'd0;
   logic        m_valid = 1'b0;

   csr_counter dut (
      .clk     (clk),
      .rstn    (rstn),
      .retired (retired),
      .read    (read),
      .modify  (modify),
      .wdata   (wdata),
      .addr    (addr),
      .rdata   (rdata),
      .valid   (valid)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic lookup(input logic [11:0] ad, output logic hit, output logic wr,
                         output logic [31:0] w);
      hit = 1'b1;
      wr  = 1'b0;
      w   = 32'd0;
      case (ad)
         12'hB00: begin w = m_cyc[31:0];  wr = 1'b1; end
         12'hB80: begin w = m_cyc[63:32]; wr = 1'b1; end
         12'hB02: begin w = m_ins[31:0];  wr = 1'b1; end
         12'hB82: begin w = m_ins[63:32]; wr = 1'b1; end
         12'hC00, 12'hC01: w = m_cyc[31:0];
         12'hC80, 12'hC81: w = m_cyc[63:32];
         12'hC02: w = m_ins[31:0];
         12'hC82: w = m_ins[63:32];
         default: hit = 1'b0;
      endcase
   endtask

   // Advance the reference by one rising edge and queue the expected outputs
   task automatic model_step(input logic rd, input logic [1:0] md, input logic [31:0] wd,
                             input logic [11:0] ad, input logic rt, input string tag);
      logic        hit, wr;
      logic [31:0] w, nw;
      logic [63:0] nc, ni;
      exp_t        e;
      lookup(ad, hit, wr, w);
      nc = m_cyc + 64'd1;
      ni = m_ins + (rt ? 64'd1 : 64'd0);
      if (rd && wr && md != 2'b00) begin
         nw = (md == 2'b01) ? wd : (md == 2'b10) ? (w | wd) : (w & ~wd);
         case (ad)
            12'hB00: nc = {m_cyc[63:32], nw};
            12'hB80: nc = {nw, nc[31:0]};
            12'hB02: ni = {m_ins[63:32], nw};
            12'hB82: ni = {nw, ni[31:0]};
            default: ;
         endcase
      end
      if (rd) m_rdata = hit ? w : 32'd0;
      m_valid = rd && hit;
      m_cyc = nc;
      m_ins = ni;
      e.tag = tag;
      e.v   = m_valid;
      e.d   = m_rdata;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of stimulus, let the edge occur, then score the result
   task automatic cyc(input logic rd, input logic [1:0] md, input logic [31:0] wd,
                      input logic [11:0] ad, input logic rt, input string tag);
      exp_t e;
      read    = rd;
      modify  = md;
      wdata   = wd;
      addr    = ad;
      retired = rt;
      @(posedge clk);
      model_step(rd, md, wd, ad, rt, tag);
      #1;
      if (exp_q.size() == 0) begin
         check_val({tag, "_queue_empty"}, 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         check_val({e.tag, "_valid"}, {63'd0, valid}, {63'd0, e.v});
         check_val({e.tag, "_rdata"}, {32'd0, rdata}, {32'd0, e.d});
      end
      @(negedge clk);
      read    = 1'b0;
      modify  = 2'b00;
      retired = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 32'd0, 12'h000, 1'b0, "idle");
   endtask

   initial begin
      logic [11:0] alist [12];
      alist = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC01,
                12'hC80, 12'hC81, 12'hC02, 12'hC82, 12'h300, 12'hB01};

      // Reset state
      #20;
      check_val("rst_valid", {63'd0, valid}, 64'd0);
      check_val("rst_rdata", {32'd0, rdata}, 64'd0);

      // Release at t=40 (a falling edge); first counting edge is at 45
      #20;
      rstn = 1'b1;
      idle(2);
      cyc(1'b1, 2'b00, 32'd0, 12'hC00, 1'b0, "rd_cycle");
      check_val("plan_cycle_eq2", {32'd0, rdata}, 64'd2);
      cyc(1'b1, 2'b00, 32'd0, 12'hC01, 1'b0, "rd_time");
      check_val("plan_time_eq3", {32'd0, rdata}, 64'd3);

      // Retire counting
      for (int i = 0; i < 5; i++) cyc(1'b0, 2'b00, 32'd0, 12'h000, 1'b1, "retire");
      cyc(1'b1, 2'b00, 32'd0, 12'hC02, 1'b0, "rd_instret");
      check_val("plan_instret_eq5", {32'd0, rdata}, 64'd5);
      cyc(1'b1, 2'b00, 32'd0, 12'hC82, 1'b0, "rd_instreth");
      cyc(1'b1, 2'b00, 32'd0, 12'hB02, 1'b0, "rd_minstret");
      check_val("plan_minstret_eq5", {32'd0, rdata}, 64'd5);

      // Write low cycle word, watch carry into the high word
      cyc(1'b1, 2'b01, 32'hFFFF_FFFE, 12'hB00, 1'b0, "wr_mcycle");
      idle(1);
      cyc(1'b1, 2'b00, 32'd0, 12'hB00, 1'b0, "rd_mcycle_ff");
      check_val("plan_mcycle_ffffffff", {32'd0, rdata}, 64'hFFFF_FFFF);
      cyc(1'b1, 2'b00, 32'd0, 12'hB80, 1'b0, "rd_mcycleh_carry");
      check_val("plan_mcycleh_eq1", {32'd0, rdata}, 64'd1);

      // Set / clear on minstret
      cyc(1'b1, 2'b01, 32'h0F0, 12'hB02, 1'b0, "wr_minstret");
      cyc(1'b1, 2'b10, 32'h300, 12'hB02, 1'b0, "set_minstret");
      cyc(1'b1, 2'b00, 32'd0,   12'hB02, 1'b0, "rd_after_set");
      check_val("plan_set_3f0", {32'd0, rdata}, 64'h3F0);
      cyc(1'b1, 2'b11, 32'h0F0, 12'hB02, 1'b0, "clr_minstret");
      cyc(1'b1, 2'b00, 32'd0,   12'hB02, 1'b0, "rd_after_clr");
      check_val("plan_clr_300", {32'd0, rdata}, 64'h300);

      // Write wins over a coincident retire
      cyc(1'b1, 2'b01, 32'h10, 12'hB02, 1'b1, "wr_minstret_retire");
      cyc(1'b1, 2'b00, 32'd0,  12'hB02, 1'b1, "rd_minstret_dropped");
      check_val("retire_dropped", {32'd0, rdata}, 64'h10);
      cyc(1'b1, 2'b00, 32'd0,  12'hC02, 1'b0, "rd_instret_after");

      // Modify to a read-only alias is ignored
      cyc(1'b1, 2'b01, 32'h1234, 12'hC00, 1'b0, "wr_ro_cycle");
      check_val("ro_write_valid", {63'd0, valid}, 64'd1);
      cyc(1'b1, 2'b00, 32'd0, 12'hC00, 1'b0, "rd_cycle_after_ro");

      // Unrecognised address, then hold behaviour with read low
      cyc(1'b1, 2'b00, 32'd0, 12'h300, 1'b0, "rd_unmapped");
      check_val("unmapped_valid", {63'd0, valid}, 64'd0);
      check_val("unmapped_rdata", {32'd0, rdata}, 64'd0);
      cyc(1'b1, 2'b01, 32'hDEAD, 12'hB01, 1'b0, "wr_unmapped");
      cyc(1'b1, 2'b00, 32'd0, 12'hC80, 1'b0, "rd_cycleh");
      idle(2);

      // 64-bit wrap of both counters
      cyc(1'b1, 2'b01, 32'hFFFF_FFFF, 12'hB80, 1'b0, "wr_mcycleh");
      cyc(1'b1, 2'b01, 32'hFFFF_FFFE, 12'hB00, 1'b0, "wr_mcycle_wrap");
      idle(1);
      cyc(1'b1, 2'b00, 32'd0, 12'hB00, 1'b0, "rd_mcycle_pre_wrap");
      cyc(1'b1, 2'b00, 32'd0, 12'hC81, 1'b0, "rd_timeh_wrapped");
      check_val("cycle_wrap_hi", {32'd0, rdata}, 64'd0);
      cyc(1'b1, 2'b01, 32'hFFFF_FFFF, 12'hB82, 1'b0, "wr_minstreth");
      cyc(1'b1, 2'b01, 32'hFFFF_FFFF, 12'hB02, 1'b0, "wr_minstret_ff");
      cyc(1'b0, 2'b00, 32'd0, 12'h000, 1'b1, "retire_wrap");
      cyc(1'b1, 2'b00, 32'd0, 12'hB82, 1'b0, "rd_minstreth_wrap");
      check_val("instret_wrap_hi", {32'd0, rdata}, 64'd0);
      cyc(1'b1, 2'b00, 32'd0, 12'hB02, 1'b0, "rd_minstret_wrap");
      check_val("instret_wrap_lo", {32'd0, rdata}, 64'd0);

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         logic [11:0] a;
         logic [1:0]  m;
         logic        r;
         a = alist[$urandom_range(0, 11)];
         m = 2'($urandom_range(0, 3));
         r = 1'($urandom_range(0, 1));
         if (a == 12'hB82 && m != 2'b00) r = 1'b0;
         cyc(1'($urandom_range(0, 3) != 0), m, $urandom, a, r, "rand");
      end

      // Asynchronous reset between edges
      cyc(1'b1, 2'b00, 32'd0, 12'hC00, 1'b0, "rd_before_arst");
      #2;
      rstn = 1'b0;
      #1;
      check_val("arst_valid", {63'd0, valid}, 64'd0);
      check_val("arst_rdata", {32'd0, rdata}, 64'd0);
      m_cyc   = 64'd0;
      m_ins   = 64'd0;
      m_rdata = 32'd0;
      m_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      idle(2);
      cyc(1'b1, 2'b00, 32'd0, 12'hC00, 1'b0, "rd_cycle_post_arst");
      check_val("arst_cycle_eq2", {32'd0, rdata}, 64'd2);
      cyc(1'b1, 2'b00, 32'd0, 12'hB02, 1'b0, "rd_instret_post_arst");
      check_val("arst_instret_eq0", {32'd0, rdata}, 64'd0);

      check_val("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
